// File: rtl/execute_pkg.sv
// execute_pkg: shared constants and types for the RV32I execute stage.
//   - datapath widths, opcode / funct3 / funct7 encodings
//   - alu_op_t (ALU operation select), exec_state_t (stage FSM states)
//   - immediate extraction and funct3 -> ALU op helpers
package execute_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned MUL_CNT_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        MUL,
        OUT
    } exec_state_t;

    // Operation for funct7=0000000 encodings (shared by OP and OP-IMM).
    function automatic alu_op_t base_alu_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    // I-type immediate, sign-extended from instruction bit 31.
    function automatic logic [XLEN-1:0] imm_i(input logic [11:0] imm12);
        return {{(XLEN-12){imm12[11]}}, imm12};
    endfunction

    // U-type immediate, upper 20 bits with zero low bits.
    function automatic logic [XLEN-1:0] imm_u(input logic [19:0] imm20);
        return {imm20, 12'b0};
    endfunction

endpackage

// File: rtl/execute_if.sv
// execute_if: handshake / register-file bundle around the execute stage.
//   decode side : IN_VALID, INSTR, PC, STALLED
//   control     : HALT, NEXT_STALLED
//   reg reads   : RCH1/2_IDX (out), RCH1/2_VAL, RCH1/2_RESP (in)
//   reg write   : WCH1_IDX, WCH1_VAL
//   downstream  : VALID, RESULT, RD, ILLEGAL
// slave is the execute stage itself, master is its environment.
interface execute_if;
    import execute_pkg::*;

    logic                 IN_VALID;
    logic [XLEN-1:0]      INSTR;
    logic [XLEN-1:0]      PC;
    logic                 HALT;
    logic                 STALLED;
    logic                 NEXT_STALLED;
    logic [REG_IDX_W-1:0] RCH1_IDX;
    logic [REG_IDX_W-1:0] RCH2_IDX;
    logic [XLEN-1:0]      RCH1_VAL;
    logic [XLEN-1:0]      RCH2_VAL;
    logic                 RCH1_RESP;
    logic                 RCH2_RESP;
    logic [REG_IDX_W-1:0] WCH1_IDX;
    logic [XLEN-1:0]      WCH1_VAL;
    logic                 VALID;
    logic [XLEN-1:0]      RESULT;
    logic [REG_IDX_W-1:0] RD;
    logic                 ILLEGAL;

    modport slave (
        input  IN_VALID, INSTR, PC, HALT, NEXT_STALLED,
               RCH1_VAL, RCH2_VAL, RCH1_RESP, RCH2_RESP,
        output STALLED, RCH1_IDX, RCH2_IDX, WCH1_IDX, WCH1_VAL,
               VALID, RESULT, RD, ILLEGAL
    );

    modport master (
        output IN_VALID, INSTR, PC, HALT, NEXT_STALLED,
               RCH1_VAL, RCH2_VAL, RCH1_RESP, RCH2_RESP,
        input  STALLED, RCH1_IDX, RCH2_IDX, WCH1_IDX, WCH1_VAL,
               VALID, RESULT, RD, ILLEGAL
    );

endinterface

// File: rtl/execute_alu.sv
// execute_alu: combinational RV32I integer ALU.
//   op_i : operation select
//   a_i  : operand A
//   b_i  : operand B (shift amount taken from b_i[4:0])
//   y_o  : result, wrapping modulo 2^XLEN
module execute_alu
    import execute_pkg::*;
(
    input  alu_op_t         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o = XLEN'($signed(a_i) < $signed(b_i));
            ALU_SLTU: y_o = XLEN'(a_i < b_i);
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = XLEN'($signed(a_i) >>> shamt);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// execute: execute stage of the in-order RV32I pipeline.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : execute_if.slave (decode input, reg-file read/write channels,
//              downstream VALID/RESULT/RD/ILLEGAL handshake)
// Optional multiplier enabled by defining EXECUTE_MUL_EN (MUL: 32-cycle
// shift-add); without it every funct7=0000001 OP encoding is illegal.
module execute
    import execute_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    execute_if.slave bus
);

    exec_state_t          state_q, state_d;
    logic [XLEN-1:0]      instr_q, instr_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      result_q, result_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic                 valid_q, valid_d;
    logic                 illegal_q, illegal_d;
`ifdef EXECUTE_MUL_EN
    logic [XLEN-1:0]      mul_a_q, mul_a_d;
    logic [XLEN-1:0]      mul_b_q, mul_b_d;
    logic [XLEN-1:0]      mul_acc_q, mul_acc_d;
    logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(XLEN - 1);
`endif

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            need_rs1;
    logic            need_rs2;
    logic            dec_illegal;
    logic            dec_mul;
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;

    logic stalled_c;
    logic out_fire_c;
    logic accept_c;
    logic read_done_c;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // Decode of the held instruction: operand needs, ALU op/operands, legality.
    always_comb begin
        need_rs1    = 1'b0;
        need_rs2    = 1'b0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        alu_op      = ALU_ADD;
        alu_a       = bus.RCH1_VAL;
        alu_b       = bus.RCH2_VAL;
        case (opcode)
            OPC_OP: begin
                need_rs1 = 1'b1;
                need_rs2 = 1'b1;
                case (funct7)
                    F7_BASE: alu_op = base_alu_op(funct3);
                    F7_ALT: begin
                        if (funct3 == F3_ADD_SUB)      alu_op = ALU_SUB;
                        else if (funct3 == F3_SRL_SRA) alu_op = ALU_SRA;
                        else                           dec_illegal = 1'b1;
                    end
`ifdef EXECUTE_MUL_EN
                    F7_MULDIV: begin
                        if (funct3 == F3_ADD_SUB) dec_mul = 1'b1;
                        else                      dec_illegal = 1'b1;
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                need_rs1 = 1'b1;
                alu_b    = imm_i(instr_q[31:20]);
                alu_op   = base_alu_op(funct3);
                // Shift-immediates reuse imm[11:5] as funct7.
                if (funct3 == F3_SLL && funct7 != F7_BASE) begin
                    dec_illegal = 1'b1;
                end
                if (funct3 == F3_SRL_SRA) begin
                    if (funct7 == F7_ALT)       alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE) dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                alu_a = '0;
                alu_b = imm_u(instr_q[31:12]);
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u(instr_q[31:12]);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    execute_alu u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    // Handshake terms; accept implies IDLE, or OUT in a releasing cycle.
    assign stalled_c   = RST | bus.HALT | (state_q == READ) | (state_q == MUL)
                       | ((state_q == OUT) & bus.NEXT_STALLED);
    assign out_fire_c  = valid_q & ~bus.NEXT_STALLED & ~bus.HALT & ~RST;
    assign accept_c    = bus.IN_VALID & ~stalled_c;
    assign read_done_c = (~need_rs1 | bus.RCH1_RESP) & (~need_rs2 | bus.RCH2_RESP);

    // Next-state and register updates; HALT freezes everything.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        result_d  = result_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
`ifdef EXECUTE_MUL_EN
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_acc_d = mul_acc_q;
        mul_cnt_d = mul_cnt_q;
`endif
        if (!bus.HALT) begin
            case (state_q)
                IDLE: ;
                READ: begin
                    if (read_done_c) begin
`ifdef EXECUTE_MUL_EN
                        if (dec_mul) begin
                            state_d   = MUL;
                            mul_a_d   = bus.RCH1_VAL;
                            mul_b_d   = bus.RCH2_VAL;
                            mul_acc_d = '0;
                            mul_cnt_d = '0;
                        end else
`endif
                        begin
                            state_d   = OUT;
                            valid_d   = 1'b1;
                            illegal_d = dec_illegal;
                            result_d  = dec_illegal ? '0 : alu_y;
                            rd_d      = dec_illegal ? '0 : instr_q[11:7];
                        end
                    end
                end
`ifdef EXECUTE_MUL_EN
                MUL: begin
                    // One partial product per cycle; LSB of B selects A.
                    mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
                    mul_a_d   = mul_a_q << 1;
                    mul_b_d   = mul_b_q >> 1;
                    mul_cnt_d = mul_cnt_q + MUL_CNT_W'(1);
                    if (mul_cnt_q == MUL_LAST) begin
                        state_d   = OUT;
                        valid_d   = 1'b1;
                        illegal_d = 1'b0;
                        result_d  = mul_acc_d;
                        rd_d      = instr_q[11:7];
                    end
                end
`endif
                OUT: begin
                    if (out_fire_c) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (accept_c) begin
                state_d = READ;
                instr_d = bus.INSTR;
                pc_d    = bus.PC;
                valid_d = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef EXECUTE_MUL_EN
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_acc_q <= '0;
            mul_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
`ifdef EXECUTE_MUL_EN
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_acc_q <= mul_acc_d;
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

    // Read indices come straight from the latched instruction.
    assign bus.RCH1_IDX = instr_q[19:15];
    assign bus.RCH2_IDX = instr_q[24:20];

    // Writeback pulses only in the cycle the result is handed downstream.
    assign bus.WCH1_IDX = out_fire_c ? rd_q : '0;
    assign bus.WCH1_VAL = out_fire_c ? result_q : '0;

    assign bus.STALLED  = stalled_c;
    assign bus.VALID    = valid_q;
    assign bus.RESULT   = result_q;
    assign bus.RD       = rd_q;
    assign bus.ILLEGAL  = illegal_q;

endmodule

// File: tb/tb_execute.sv
// tb_execute: directed self-checking bench for the execute stage.
module tb_execute;

    logic CLK = 1'b0;
    logic RST;

    execute_if bus ();

    execute dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [4:0]  last_idx = '0;
    logic [31:0] last_val = '0;
    int w0;
    int edges;

    // Record every writeback pulse, sampled mid-cycle.
    always @(negedge CLK) begin
        if (bus.WCH1_IDX != 5'd0) begin
            wr_cnt   = wr_cnt + 1;
            last_idx = bus.WCH1_IDX;
            last_val = bus.WCH1_VAL;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_rd(input logic [31:0] v1, input logic [31:0] v2,
                          input logic r1, input logic r2);
        bus.RCH1_VAL  = v1;
        bus.RCH2_VAL  = v2;
        bus.RCH1_RESP = r1;
        bus.RCH2_RESP = r2;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bus.IN_VALID = 1'b1;
        bus.INSTR    = instr;
        bus.PC       = pc;
        tick();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic run(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] v1, input logic [31:0] v2);
        set_rd(v1, v2, 1'b1, 1'b1);
        issue(instr, pc);
        tick();
    endtask

    initial begin
        bus.IN_VALID     = 1'b0;
        bus.INSTR        = '0;
        bus.PC           = '0;
        bus.HALT         = 1'b0;
        bus.NEXT_STALLED = 1'b0;
        set_rd('0, '0, 1'b0, 1'b0);
        RST = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid",   32'(bus.VALID), 32'd0);
        chk("rst_result",  bus.RESULT, 32'd0);
        chk("rst_rd",      32'(bus.RD), 32'd0);
        chk("rst_illegal", 32'(bus.ILLEGAL), 32'd0);
        chk("rst_wch_idx", 32'(bus.WCH1_IDX), 32'd0);
        chk("rst_wch_val", bus.WCH1_VAL, 32'd0);
        chk("rst_rch1",    32'(bus.RCH1_IDX), 32'd0);
        chk("rst_stalled", 32'(bus.STALLED), 32'd1);
        RST = 1'b0;
        #1;
        chk("idle_stalled", 32'(bus.STALLED), 32'd0);

        // ADDI x1,x0,5 with immediate response
        w0 = wr_cnt;
        set_rd(32'd0, 32'd0, 1'b1, 1'b1);
        issue(32'h00500093, 32'h0);
        chk("addi_read_stalled", 32'(bus.STALLED), 32'd1);
        chk("addi_read_valid",   32'(bus.VALID), 32'd0);
        chk("addi_rch2_idx",     32'(bus.RCH2_IDX), 32'd5);
        tick();
        chk("addi_valid",   32'(bus.VALID), 32'd1);
        chk("addi_result",  bus.RESULT, 32'd5);
        chk("addi_rd",      32'(bus.RD), 32'd1);
        chk("addi_illegal", 32'(bus.ILLEGAL), 32'd0);
        chk("addi_wch_idx", 32'(bus.WCH1_IDX), 32'd1);
        chk("addi_wch_val", bus.WCH1_VAL, 32'd5);
        tick();
        chk("addi_valid_drop", 32'(bus.VALID), 32'd0);
        tick();
        chk("addi_writes",     32'(wr_cnt - w0), 32'd1);
        chk("addi_last_idx",   32'(last_idx), 32'd1);
        chk("addi_last_val",   last_val, 32'd5);

        // SUB x3,x1,x2 with rs2 response delayed 3 cycles
        w0 = wr_cnt;
        set_rd(32'd3, 32'd7, 1'b1, 1'b0);
        issue(32'h402081B3, 32'h4);
        chk("sub_rch1_idx", 32'(bus.RCH1_IDX), 32'd1);
        chk("sub_rch2_idx", 32'(bus.RCH2_IDX), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sub_wait_stalled", 32'(bus.STALLED), 32'd1);
            chk("sub_wait_valid",   32'(bus.VALID), 32'd0);
        end
        bus.RCH2_RESP = 1'b1;
        tick();
        chk("sub_valid",  32'(bus.VALID), 32'd1);
        chk("sub_result", bus.RESULT, 32'hFFFFFFFC);
        chk("sub_rd",     32'(bus.RD), 32'd3);
        tick();
        tick();
        chk("sub_writes", 32'(wr_cnt - w0), 32'd1);

        // SRAI x4,x5,4 on a negative value
        run(32'h4042D213, 32'h8, 32'h80000000, 32'h0);
        chk("srai_result", bus.RESULT, 32'hF8000000);
        chk("srai_rd",     32'(bus.RD), 32'd4);
        tick();

        // SLTU x6,x7,x8 then back-to-back AUIPC x9,0x12345
        run(32'h0083B333, 32'hC, 32'h1, 32'hFFFFFFFF);
        chk("sltu_result", bus.RESULT, 32'd1);
        bus.IN_VALID = 1'b1;
        bus.INSTR    = 32'h12345497;
        bus.PC       = 32'h100;
        #1;
        chk("b2b_stalled", 32'(bus.STALLED), 32'd0);
        chk("b2b_wch_idx", 32'(bus.WCH1_IDX), 32'd6);
        tick();
        bus.IN_VALID = 1'b0;
        chk("b2b_valid_gap", 32'(bus.VALID), 32'd0);
        tick();
        chk("auipc_valid",  32'(bus.VALID), 32'd1);
        chk("auipc_result", bus.RESULT, 32'h12345100);
        chk("auipc_rd",     32'(bus.RD), 32'd9);
        tick();

        // LUI x10 held by NEXT_STALLED for 4 cycles
        w0 = wr_cnt;
        bus.NEXT_STALLED = 1'b1;
        run(32'hABCDE537, 32'h0, 32'h0, 32'h0);
        chk("lui_result", bus.RESULT, 32'hABCDE000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid",   32'(bus.VALID), 32'd1);
            chk("hold_result",  bus.RESULT, 32'hABCDE000);
            chk("hold_wch_idx", 32'(bus.WCH1_IDX), 32'd0);
            chk("hold_stalled", 32'(bus.STALLED), 32'd1);
        end
        bus.NEXT_STALLED = 1'b0;
        #1;
        chk("rel_wch_idx", 32'(bus.WCH1_IDX), 32'd10);
        chk("rel_wch_val", bus.WCH1_VAL, 32'hABCDE000);
        tick();
        chk("rel_valid_drop", 32'(bus.VALID), 32'd0);
        chk("rel_writes",     32'(wr_cnt - w0), 32'd1);

        // ADD x11,x12,x13 with HALT for 3 cycles in READ, then in OUT
        w0 = wr_cnt;
        set_rd(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        issue(32'h00D605B3, 32'h10);
        bus.HALT      = 1'b1;
        bus.RCH2_RESP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_read_valid",   32'(bus.VALID), 32'd0);
            chk("halt_read_stalled", 32'(bus.STALLED), 32'd1);
            chk("halt_rch1_idx",     32'(bus.RCH1_IDX), 32'd12);
        end
        bus.HALT = 1'b0;
        tick();
        chk("add_valid",  32'(bus.VALID), 32'd1);
        chk("add_result", bus.RESULT, 32'd1);
        chk("add_rd",     32'(bus.RD), 32'd11);
        bus.HALT = 1'b1;
        #1;
        chk("halt_out_wch_idx", 32'(bus.WCH1_IDX), 32'd0);
        tick();
        chk("halt_out_valid", 32'(bus.VALID), 32'd1);
        bus.HALT = 1'b0;
        #1;
        chk("add_wch_idx", 32'(bus.WCH1_IDX), 32'd11);
        tick();
        chk("add_writes", 32'(wr_cnt - w0), 32'd1);

        // Illegal opcode, illegal OP funct7, and rd=x0
        w0 = wr_cnt;
        run(32'h0000007F, 32'h0, 32'h0, 32'h0);
        chk("ill_valid",   32'(bus.VALID), 32'd1);
        chk("ill_illegal", 32'(bus.ILLEGAL), 32'd1);
        chk("ill_result",  bus.RESULT, 32'd0);
        chk("ill_rd",      32'(bus.RD), 32'd0);
        chk("ill_wch_idx", 32'(bus.WCH1_IDX), 32'd0);
        tick();
        run(32'h40001033, 32'h0, 32'h5, 32'h1);
        chk("ill_f7_illegal", 32'(bus.ILLEGAL), 32'd1);
        chk("ill_f7_result",  bus.RESULT, 32'd0);
        tick();
        run(32'h00100013, 32'h0, 32'h0, 32'h0);
        chk("x0_valid",   32'(bus.VALID), 32'd1);
        chk("x0_illegal", 32'(bus.ILLEGAL), 32'd0);
        chk("x0_result",  bus.RESULT, 32'd1);
        chk("x0_wch_idx", 32'(bus.WCH1_IDX), 32'd0);
        tick();
        tick();
        chk("no_writes", 32'(wr_cnt - w0), 32'd0);

        // Reset while in READ drops the instruction
        w0 = wr_cnt;
        set_rd(32'd4, 32'd4, 1'b1, 1'b0);
        issue(32'h00D605B3, 32'h20);
        RST = 1'b1;
        #1;
        chk("rstr_stalled", 32'(bus.STALLED), 32'd1);
        tick();
        chk("rstr_valid",   32'(bus.VALID), 32'd0);
        chk("rstr_result",  bus.RESULT, 32'd0);
        chk("rstr_rch1",    32'(bus.RCH1_IDX), 32'd0);
        chk("rstr_wch_idx", 32'(bus.WCH1_IDX), 32'd0);
        RST = 1'b0;
        bus.RCH2_RESP = 1'b1;
        tick();
        tick();
        chk("rstr_valid_after", 32'(bus.VALID), 32'd0);
        chk("rstr_writes",      32'(wr_cnt - w0), 32'd0);

        // MUL x14,x1,x2: 0x10000 * 0x10001
        w0 = wr_cnt;
        set_rd(32'h00010000, 32'h00010001, 1'b1, 1'b1);
        issue(32'h02208733, 32'h30);
        edges = 1;
        do begin
            tick();
            edges++;
        end while (bus.VALID !== 1'b1 && edges < 40);
`ifdef EXECUTE_MUL_EN
        chk("mul_latency", 32'(edges), 32'd34);
        chk("mul_illegal", 32'(bus.ILLEGAL), 32'd0);
        chk("mul_result",  bus.RESULT, 32'h00010000);
        chk("mul_rd",      32'(bus.RD), 32'd14);
        tick();
        chk("mul_writes",  32'(wr_cnt - w0), 32'd1);
`else
        chk("mul_latency", 32'(edges), 32'd2);
        chk("mul_illegal", 32'(bus.ILLEGAL), 32'd1);
        chk("mul_result",  bus.RESULT, 32'd0);
        tick();
        chk("mul_writes",  32'(wr_cnt - w0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
